// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the raster coordinate type used by the
// timing generator, color_mapper and the motion blocks.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int H_TOTAL  = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL  = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int HS_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int HS_END   = HS_START + DEF_H_SYNC;
  localparam int VS_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int VS_END   = VS_START + DEF_V_SYNC;

  typedef logic [9:0] coord_t;

  function automatic int span_total(int vis, int fp, int sync, int bp);
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the generator (master) presents coordinates and
// syncs; color_mapper and the DAC side (slave) consume them.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  // No handshake: every signal is valid on every Clk; pixel_ce marks the
  // single Clk per pixel in which the raster advances.
  logic   pixel_clk;
  logic   pixel_ce;
  coord_t DrawX;
  coord_t DrawY;
  logic   hs;
  logic   vs;
  logic   blank;
  logic   sync;
  logic   frame_start;

  modport master (
    output pixel_clk, pixel_ce, DrawX, DrawY, hs, vs, blank, sync, frame_start
  );

  modport slave (
    input pixel_clk, pixel_ce, DrawX, DrawY, hs, vs, blank, sync, frame_start
  );

endinterface

// File: rtl/vga_pixel_div.sv
// Divides Clk by CLK_DIV into a one-Clk pixel enable and a registered
// pixel clock that is high for the upper half of each divider period.
module vga_pixel_div #(
  parameter int CLK_DIV = 2
) (
  input  logic Clk,
  input  logic Reset,
  output logic o_pixel_ce,
  output logic o_pixel_clk
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] r_div;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_div       <= '0;
      o_pixel_ce  <= 1'b0;
      o_pixel_clk <= 1'b0;
    end else begin
      r_div       <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      o_pixel_ce  <= (r_div == DIV_LAST);
      o_pixel_clk <= (r_div >= DIV_HALF);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: horizontal/vertical counters advanced on pixel_ce and a
// registered decode of coordinates, syncs, blank and the frame-start tick.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic             Clk,
  input  logic             Reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOT = span_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = span_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  localparam coord_t H_LAST = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST = coord_t'(V_TOT - 1);
  localparam coord_t H_VIS  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS  = coord_t'(V_VISIBLE);
  localparam coord_t HS_S   = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_E   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t VS_S   = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_E   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  logic   w_pixel_ce;
  logic   w_pixel_clk;
  logic   w_h_last;
  logic   w_v_last;
  coord_t r_hc;
  coord_t r_vc;
  coord_t r_draw_x;
  coord_t r_draw_y;
  logic   r_hs;
  logic   r_vs;
  logic   r_blank;
  logic   r_frame_start;

  vga_pixel_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_div (
    .Clk         (Clk),
    .Reset       (Reset),
    .o_pixel_ce  (w_pixel_ce),
    .o_pixel_clk (w_pixel_clk)
  );

  assign w_h_last = (r_hc == H_LAST);
  assign w_v_last = (r_vc == V_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_pixel_ce) begin
      if (w_h_last) begin
        r_hc <= '0;
        r_vc <= w_v_last ? '0 : r_vc + 1'b1;
      end else begin
        r_hc <= r_hc + 1'b1;
      end
    end
  end

  // Decode from the pre-advance counters so all outputs move together,
  // one Clk behind hc/vc.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_draw_x      <= '0;
      r_draw_y      <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_draw_x      <= r_hc;
      r_draw_y      <= r_vc;
      r_hs          <= ~((r_hc >= HS_S) && (r_hc < HS_E));
      r_vs          <= ~((r_vc >= VS_S) && (r_vc < VS_E));
      r_blank       <= (r_hc < H_VIS) && (r_vc < V_VIS);
      r_frame_start <= w_pixel_ce && w_h_last && w_v_last;
    end
  end

  assign vga.pixel_clk   = w_pixel_clk;
  assign vga.pixel_ce    = w_pixel_ce;
  assign vga.DrawX       = r_draw_x;
  assign vga.DrawY       = r_draw_y;
  assign vga.hs          = r_hs;
  assign vga.vs          = r_vs;
  assign vga.blank       = r_blank;
  assign vga.sync        = 1'b0;
  assign vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a reduced raster, built with CLK_DIV=2
// and CLK_DIV=4, checked every Clk against a closed-form timing model.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int HV = 16, HF = 4, HSY = 6, HB = 6;
  localparam int VV = 12, VF = 2, VSY = 2, VB = 3;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VT = VV + VF + VSY + VB;

  logic Clk;
  logic Reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [26:0] exp2_q[$];
  logic [26:0] exp4_q[$];

  vga_timing_gen_if vif2 ();
  vga_timing_gen_if vif4 ();

  vga_timing_gen #(
    .CLK_DIV(2), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut2 (
    .Clk   (Clk),
    .Reset (Reset),
    .vga   (vif2)
  );

  vga_timing_gen #(
    .CLK_DIV(4), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut4 (
    .Clk   (Clk),
    .Reset (Reset),
    .vga   (vif4)
  );

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Expected outputs after the t-th Clk edge since Reset was released
  // (t=0: Reset sampled high). Fields: pclk, ce, x, y, hs, vs, blank, sync, fs.
  function automatic logic [26:0] model(int t, int d);
    int   p, hpos, vpos;
    logic ce, pclk, ce_prev, hs, vs, blank, fs;
    if (t == 0) return {1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ce      = (t % d == 0);
    pclk    = (((t - 1) % d) >= d / 2);
    ce_prev = (t >= 2) && ((t - 1) % d == 0);
    p       = (t >= 2) ? (t - 2) / d : 0;
    hpos    = p % HT;
    vpos    = (p / HT) % VT;
    hs      = !(hpos >= HV + HF && hpos < HV + HF + HSY);
    vs      = !(vpos >= VV + VF && vpos < VV + VF + VSY);
    blank   = (hpos < HV) && (vpos < VV);
    fs      = ce_prev && (p % (HT * VT) == HT * VT - 1);
    return {pclk, ce, 10'(hpos), 10'(vpos), hs, vs, blank, 1'b0, fs};
  endfunction

  // driver
  int t_rel = 0;

  task automatic step(input bit rst);
    @(negedge Clk);
    Reset = rst;
    t_rel = rst ? 0 : t_rel + 1;
    exp2_q.push_back(model(t_rel, 2));
    exp4_q.push_back(model(t_rel, 4));
  endtask

  // scoreboard
  task automatic check_field(input string name, input int d, input int t,
                             input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s div%0d @%0t: got %0d, expected %0d", name, d, $time, act, exp);
    end
  endtask

  task automatic compare_all(input int d, input logic [26:0] e, input logic [26:0] a);
    check_field("pixel_clk",   d, 0, int'(a[26]),    int'(e[26]));
    check_field("pixel_ce",    d, 0, int'(a[25]),    int'(e[25]));
    check_field("DrawX",       d, 0, int'(a[24:15]), int'(e[24:15]));
    check_field("DrawY",       d, 0, int'(a[14:5]),  int'(e[14:5]));
    check_field("hs",          d, 0, int'(a[4]),     int'(e[4]));
    check_field("vs",          d, 0, int'(a[3]),     int'(e[3]));
    check_field("blank",       d, 0, int'(a[2]),     int'(e[2]));
    check_field("sync",        d, 0, int'(a[1]),     int'(e[1]));
    check_field("frame_start", d, 0, int'(a[0]),     int'(e[0]));
  endtask

  // monitor
  always @(posedge Clk) begin
    logic [26:0] e;
    #1;
    if (exp2_q.size() > 0) begin
      e = exp2_q.pop_front();
      compare_all(2, e, {vif2.pixel_clk, vif2.pixel_ce, vif2.DrawX, vif2.DrawY,
                         vif2.hs, vif2.vs, vif2.blank, vif2.sync, vif2.frame_start});
    end
    if (exp4_q.size() > 0) begin
      e = exp4_q.pop_front();
      compare_all(4, e, {vif4.pixel_clk, vif4.pixel_ce, vif4.DrawX, vif4.DrawY,
                         vif4.hs, vif4.vs, vif4.blank, vif4.sync, vif4.frame_start});
    end
  end

  // stimulus and final report
  initial begin
    Reset = 1'b1;
    repeat (5) step(1'b1);
    repeat (2 * HT * VT * 2 + 50) step(1'b0);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(50, 1500)) step(1'b0);
      repeat ($urandom_range(1, 3)) step(1'b1);
    end
    repeat (2 * HT * VT * 4 + 50) step(1'b0);
    repeat (2) @(negedge Clk);
    check_field("queue_drain", 2, 0, exp2_q.size() + exp4_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
